// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
//   kp_state_e  : scanner FSM states
//   code_width  : width of the encoded key code for an R x C matrix
//   count_width : width of a counter that must be able to hold 'limit'
//   encode_key  : col_idx * num_rows + index of the lowest low (pressed) row
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } kp_state_e;

    // Upper bound on the row count that encode_key can handle.
    localparam int MAX_ROWS = 32;

    function automatic int code_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

    function automatic int count_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

    // Lowest pressed row wins when several keys in one column are down.
    function automatic int encode_key(input int col_idx,
                                      input logic [MAX_ROWS-1:0] pat,
                                      input int num_rows);
        int idx;
        idx = 0;
        for (int r = MAX_ROWS - 1; r >= 0; r--) begin
            if (r < num_rows && !pat[r]) idx = r;
        end
        return col_idx * num_rows + idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Scan tick generator: free-running divider producing a one-clock tick
// every SCAN_DIV clocks.
// Ports:
//   clk   in  system clock
//   rst_n in  reset, active-low, asynchronous assert
//   tick  out one-cycle pulse every SCAN_DIV clocks
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;

    assign tick = (cnt_q == DW'(SCAN_DIV - 1));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner. Drives one column low at a time, samples the rows
// through a 2-FF synchroniser, debounces press and release, and emits one
// encoded key event per accepted press.
// Ports:
//   clk       in  system clock
//   rst       in  reset, active-low, asynchronous assert, synchronised release
//   row       in  [NUM_ROWS-1:0] keypad rows, 0 = pressed
//   col       out [NUM_COLS-1:0] one-hot-low column drive
//   key_code  out [CW-1:0] col_idx*NUM_ROWS + row_idx of accepted key
//   key_valid out one-cycle pulse, key_code valid
//   key_held  out high while the accepted key is down
//   key_rpt   out high together with key_valid when the pulse is a repeat
// Build option: define KEY_REPEAT_EN to enable auto-repeat while a key is held;
// otherwise one event per press and key_rpt is tied low.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int NUM_ROWS       = 4,
    parameter int NUM_COLS       = 3,
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_TICKS = 4,
    parameter int REPEAT_DELAY   = 40,
    parameter int REPEAT_RATE    = 10,
    localparam int CW            = code_width(NUM_ROWS, NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [CW-1:0]       key_code,
    output logic                key_valid,
    output logic                key_held,
    output logic                key_rpt
);

    localparam int CIW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int DCW = count_width(DEBOUNCE_TICKS);

    if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_DELAY < 1 ||
        REPEAT_RATE < 1 || NUM_ROWS > MAX_ROWS) begin : g_cfg_check
        $error("keypad_scan_ctrl: unsupported parameter set");
    end

    // Reset: asserts immediately, releases two clocks after rst rises.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n_int = rst_sync_q[1];

    logic tick;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n_int),
        .tick  (tick)
    );

    // Rows are asynchronous to clk; idle level (all released) is all-ones.
    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] rs_q;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            row_meta_q <= '1;
            rs_q       <= '1;
        end else begin
            row_meta_q <= row;
            rs_q       <= row_meta_q;
        end
    end

    kp_state_e           state_q, state_d;
    logic [CIW-1:0]      col_idx_q, col_idx_d;
    logic [NUM_ROWS-1:0] pat_q, pat_d;
    logic [DCW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]       key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;

    logic           all_up;
    logic [CIW-1:0] next_col;
    logic           accept;
    logic           rel_done;

    assign all_up   = &rs_q;
    assign next_col = (col_idx_q == CIW'(NUM_COLS - 1)) ? '0 : col_idx_q + 1'b1;

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = count_width(RPT_MAX);

    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_first_q, rpt_first_d;
    logic          key_rpt_q, key_rpt_d;
    logic [RW-1:0] rpt_lim;

    // First repeat waits REPEAT_DELAY ticks, later ones REPEAT_RATE ticks.
    assign rpt_lim = rpt_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
`endif

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        accept      = 1'b0;
        rel_done    = 1'b0;
`ifdef KEY_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
        rpt_first_d = rpt_first_q;
        key_rpt_d   = 1'b0;
`endif

        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (!all_up) begin
                        pat_d = rs_q;
                        if (DEBOUNCE_TICKS <= 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = DEB_PRESS;
                            cnt_d   = DCW'(1);
                        end
                    end else begin
                        col_idx_d = next_col;
                    end
                end
                DEB_PRESS: begin
                    if (rs_q == pat_q) begin
                        if (cnt_q >= DCW'(DEBOUNCE_TICKS - 1)) accept = 1'b1;
                        else                                   cnt_d  = cnt_q + 1'b1;
                    end else begin
                        state_d   = SCAN;
                        cnt_d     = '0;
                        col_idx_d = next_col;
                    end
                end
                HELD: begin
                    // Any non-idle pattern keeps us here: extra keys are ignored.
                    if (all_up) begin
                        if (DEBOUNCE_TICKS <= 1) begin
                            rel_done = 1'b1;
                        end else begin
                            state_d = DEB_REL;
                            cnt_d   = DCW'(1);
                        end
                    end
                end
                DEB_REL: begin
                    if (all_up) begin
                        if (cnt_q >= DCW'(DEBOUNCE_TICKS - 1)) rel_done = 1'b1;
                        else                                   cnt_d    = cnt_q + 1'b1;
                    end else begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            endcase
        end

        // rs_q equals the captured pattern whenever accept is raised.
        if (accept) begin
            state_d     = HELD;
            cnt_d       = '0;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            key_code_d  = CW'(encode_key(int'(col_idx_q), MAX_ROWS'(rs_q), NUM_ROWS));
        end

        if (rel_done) begin
            state_d    = SCAN;
            cnt_d      = '0;
            key_held_d = 1'b0;
            col_idx_d  = next_col;
        end

`ifdef KEY_REPEAT_EN
        if (tick && state_q == HELD) begin
            if (all_up) begin
                rpt_cnt_d = '0;
            end else if ((rpt_cnt_q + 1'b1) >= rpt_lim) begin
                key_valid_d = 1'b1;
                key_rpt_d   = 1'b1;
                rpt_cnt_d   = '0;
                rpt_first_d = 1'b0;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
        end

        if (accept) begin
            rpt_cnt_d   = '0;
            rpt_first_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q     <= SCAN;
            col_idx_q   <= '0;
            pat_q       <= '1;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

`ifdef KEY_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b1;
            key_rpt_q   <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_first_q <= rpt_first_d;
            key_rpt_q   <= key_rpt_d;
        end
    end

    assign key_rpt = key_rpt_q;
`else
    assign key_rpt = 1'b0;
`endif

    assign col       = ~(NUM_COLS'(1) << col_idx_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl (4x3 matrix, SCAN_DIV=4, DEBOUNCE_TICKS=3,
// REPEAT_DELAY=6, REPEAT_RATE=2). A keypad model pulls a row low while the
// column of a pressed key is driven low. Expected key events are queued as
// stimulus is applied and checked by a monitor whenever key_valid pulses.
// Honours KEY_REPEAT_EN the same way the design does.
module tb_keypad_scan_ctrl;

    localparam int NR = 4;
    localparam int NC = 3;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int RD = 6;
    localparam int RR = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] row;
    logic [NC-1:0] col;
    logic [3:0]    key_code;
    logic          key_valid;
    logic          key_held;
    logic          key_rpt;

    logic [NC-1:0][NR-1:0] keys = '0;

    typedef struct {
        logic [3:0] code;
        logic       rpt;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    keypad_scan_ctrl #(
        .NUM_ROWS       (NR),
        .NUM_COLS       (NC),
        .SCAN_DIV       (SD),
        .DEBOUNCE_TICKS (DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .key_rpt   (key_rpt)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always_comb begin
        row = '1;
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++)
                if (keys[c][r] && !col[c]) row[r] = 1'b0;
    end

    // Scoreboard monitor: every key_valid pulse must match the oldest expectation.
    initial begin
        logic prev_valid;
        int   last_pulse;
        exp_t e;
        prev_valid = 1'b0;
        last_pulse = 0;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                vectors++;
                if (prev_valid === 1'b1) begin
                    miscompares++;
                    $display("FAIL valid_width: key_valid high two cycles in a row at cyc %0d", cyc);
                end
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: code=%0d rpt=%0b, required no pulse", key_code, key_rpt);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e.code || key_rpt !== e.rpt) begin
                        miscompares++;
                        $display("FAIL pulse: code=%0d rpt=%0b, required code=%0d rpt=%0b",
                                 key_code, key_rpt, e.code, e.rpt);
                    end
                    if (e.gap > 0) begin
                        vectors++;
                        if (cyc - last_pulse != e.gap) begin
                            miscompares++;
                            $display("FAIL pulse_gap: %0d cycles, required %0d", cyc - last_pulse, e.gap);
                        end
                    end
                end
                last_pulse = cyc;
            end
            prev_valid = key_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic push_exp(input int code, input logic rpt, input int gap);
        exp_t e;
        e.code = 4'(code);
        e.rpt  = rpt;
        e.gap  = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_repeats(input int code, input int hold_ticks);
`ifdef KEY_REPEAT_EN
        for (int k = RD; k <= hold_ticks; k += RR)
            push_exp(code, 1'b1, (k == RD) ? RD * SD : RR * SD);
`else
        if (code < 0 || hold_ticks < 0) push_exp(0, 1'b0, 0);
`endif
    endtask

    task automatic wait_held(input logic lvl, input int max_cyc, output bit ok);
        int n;
        n = 0;
        while (key_held !== lvl && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        ok = (key_held === lvl);
    endtask

    // Returns at the first negedge after col switches to target.
    task automatic wait_col(input logic [NC-1:0] target, output bit ok);
        int n;
        n = 0;
        while (col === target && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (col !== target && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = (col === target);
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (col !== 3'b110 || key_code !== 4'd0 || key_valid !== 1'b0 ||
            key_held !== 1'b0 || key_rpt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: col=%b code=%0d valid=%b held=%b rpt=%b, required 110/0/0/0/0",
                     col, key_code, key_valid, key_held, key_rpt);
        end
        rst = 1'b1;
    endtask

    task automatic test_idle;
        logic [NC-1:0] v, pv;
        int n;
        pv = col;
        n  = 0;
        while (col === pv && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            v = col;
            vectors++;
            if (v !== {pv[1:0], pv[2]}) begin
                miscompares++;
                $display("FAIL idle_col_seq[%0d]: col=%b, required %b", i, v, {pv[1:0], pv[2]});
            end
            n = 0;
            while (col === v && n < 40) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (n != SD) begin
                miscompares++;
                $display("FAIL idle_col_period[%0d]: %0d cycles, required %0d", i, n, SD);
            end
            pv = v;
        end
    endtask

    // Press, hold hold_ticks ticks after accept, release; check held-fall timing.
    task automatic press_hold(input string name, input int c, input int r,
                              input int hold_ticks);
        bit ok;
        int t0;
        push_exp(c * NR + r, 1'b0, 0);
        push_repeats(c * NR + r, hold_ticks);
        keys[c][r] = 1'b1;
        wait_held(1'b1, 200, ok);
        t0 = cyc;
        vectors++;
        if (!ok || key_code !== 4'(c * NR + r)) begin
            miscompares++;
            $display("FAIL %s_accept: held=%b code=%0d, required 1/%0d", name, key_held, key_code, c * NR + r);
        end
        repeat (hold_ticks * SD + 1) @(negedge clk);
        keys = '0;
        wait_held(1'b0, 200, ok);
        vectors++;
        if (!ok || cyc - t0 != (hold_ticks + DB) * SD) begin
            miscompares++;
            $display("FAIL %s_release: held fell after %0d cycles, required %0d",
                     name, cyc - t0, (hold_ticks + DB) * SD);
        end
        vectors++;
        if (key_code !== 4'(c * NR + r)) begin
            miscompares++;
            $display("FAIL %s_code_hold: code=%0d, required %0d", name, key_code, c * NR + r);
        end
    endtask

    task automatic test_single;
        press_hold("single", 2, 0, 20);
    endtask

    task automatic test_bounce;
        bit ok;
        int n;
        wait_col(3'b101, ok);
        keys[1][2] = 1'b1;
        repeat (9) @(negedge clk);
        keys = '0;
        n = 9;
        while (col === 3'b101 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (!ok || n != 3 * SD || col !== 3'b011 || key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL bounce: col=%b after %0d cycles held=%b, required 011 after %0d held=0",
                     col, n, key_held, 3 * SD);
        end
    endtask

    task automatic test_two_keys;
        bit ok;
        int t0;
        push_exp(5, 1'b0, 0);
        wait_col(3'b101, ok);
        keys[1] = 4'b1010;
        wait_held(1'b1, 100, ok);
        t0 = cyc;
        vectors++;
        if (!ok || key_code !== 4'd5) begin
            miscompares++;
            $display("FAIL two_keys_code: held=%b code=%0d, required 1/5", key_held, key_code);
        end
        repeat (4) @(negedge clk);
        keys[1][0] = 1'b1;
        repeat (8) @(negedge clk);
        vectors++;
        if (key_held !== 1'b1 || key_code !== 4'd5) begin
            miscompares++;
            $display("FAIL two_keys_extra: held=%b code=%0d, required 1/5", key_held, key_code);
        end
        keys = '0;
        wait_held(1'b0, 100, ok);
        vectors++;
        if (!ok || cyc - t0 != 6 * SD) begin
            miscompares++;
            $display("FAIL two_keys_release: held fell after %0d cycles, required %0d", cyc - t0, 6 * SD);
        end
    endtask

    task automatic test_repeat;
        press_hold("repeat", 0, 3, 12);
    endtask

    task automatic test_back_to_back;
        int tbl_c[5] = '{0, 1, 2, 0, 2};
        int tbl_r[5] = '{3, 2, 1, 0, 3};
        for (int i = 0; i < 5; i++)
            press_hold("b2b", tbl_c[i], tbl_r[i], 1);
    endtask

    task automatic test_async_reset;
        bit ok;
        push_exp(2 * NR + 1, 1'b0, 0);
        keys[2][1] = 1'b1;
        wait_held(1'b1, 200, ok);
        vectors++;
        if (!ok || col !== 3'b011) begin
            miscompares++;
            $display("FAIL areset_setup: held=%b col=%b, required 1/011", key_held, col);
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (col !== 3'b110 || key_held !== 1'b0 || key_valid !== 1'b0 || key_code !== 4'd0) begin
            miscompares++;
            $display("FAIL areset_async: col=%b held=%b valid=%b code=%0d, required 110/0/0/0",
                     col, key_held, key_valid, key_code);
        end
        keys = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_bounce();
        test_two_keys();
        test_repeat();
        test_back_to_back();
        test_async_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_pulses: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
